// File: rtl/oled_spi_driver.sv
// SSD1306-class OLED driver: hardware reset, power-up wait, 31-byte init stream,
// then continuous 1024-byte frames fetched from the image controller over 4-wire SPI.
module oled_spi_driver #(
  parameter int CLK_DIV        = 4,
  parameter int RESET_CYCLES   = 1000,
  parameter int STARTUP_CYCLES = 1000,
  parameter int FRAME_GAP      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_to_send,
  output logic [9:0] byte_counter,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_cs,
  output logic       oled_dc,
  output logic       oled_res,
  output logic       frame_done
);

  localparam int M1    = (RESET_CYCLES > STARTUP_CYCLES) ? RESET_CYCLES : STARTUP_CYCLES;
  localparam int M2    = (M1 > FRAME_GAP) ? M1 : FRAME_GAP;
  localparam int M3    = (M2 > 2) ? M2 : 2;
  localparam int CNT_W = $clog2(M3 + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // The INIT_LOAD cycle is part of the startup wait, so the counter stops one short.
  localparam int PW_LAST = (STARTUP_CYCLES > 1) ? STARTUP_CYCLES - 2 : 0;

  typedef enum logic [2:0] {
    HW_RESET, POWER_WAIT, INIT_LOAD, DATA_ADDR, SHIFT, NEXT, GAP
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [DIV_W-1:0] div, div_d;
  logic [4:0]       half, half_d;
  logic [4:0]       idx, idx_d;
  logic [7:0]       shreg, shreg_d;
  logic             dc, dc_d;
  logic [9:0]       bc_d;
  logic             done_d;
  logic             in_shift, cs_c, sclk_c, sdin_c;

  function automatic logic [7:0] init_rom(input logic [4:0] i);
    case (i)
      5'd0:  init_rom = 8'hAE;  5'd1:  init_rom = 8'hD5;  5'd2:  init_rom = 8'h80;
      5'd3:  init_rom = 8'hA8;  5'd4:  init_rom = 8'h3F;  5'd5:  init_rom = 8'hD3;
      5'd6:  init_rom = 8'h00;  5'd7:  init_rom = 8'h40;  5'd8:  init_rom = 8'h8D;
      5'd9:  init_rom = 8'h14;  5'd10: init_rom = 8'h20;  5'd11: init_rom = 8'h00;
      5'd12: init_rom = 8'hA1;  5'd13: init_rom = 8'hC8;  5'd14: init_rom = 8'hDA;
      5'd15: init_rom = 8'h12;  5'd16: init_rom = 8'h81;  5'd17: init_rom = 8'hCF;
      5'd18: init_rom = 8'hD9;  5'd19: init_rom = 8'hF1;  5'd20: init_rom = 8'hDB;
      5'd21: init_rom = 8'h40;  5'd22: init_rom = 8'hA4;  5'd23: init_rom = 8'hA6;
      5'd24: init_rom = 8'hAF;  5'd25: init_rom = 8'h21;  5'd26: init_rom = 8'h00;
      5'd27: init_rom = 8'h7F;  5'd28: init_rom = 8'h22;  5'd29: init_rom = 8'h00;
      5'd30: init_rom = 8'h07;
      default: init_rom = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HW_RESET;
      cnt          <= '0;
      div          <= '0;
      half         <= '0;
      idx          <= '0;
      shreg        <= '0;
      dc           <= 1'b0;
      byte_counter <= '0;
      oled_sclk    <= 1'b0;
      oled_sdin    <= 1'b0;
      oled_cs      <= 1'b1;
      oled_dc      <= 1'b0;
      oled_res     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      div          <= div_d;
      half         <= half_d;
      idx          <= idx_d;
      shreg        <= shreg_d;
      dc           <= dc_d;
      byte_counter <= bc_d;
      oled_sclk    <= sclk_c;
      oled_sdin    <= sdin_c;
      oled_cs      <= cs_c;
      oled_dc      <= dc;
      oled_res     <= (state != HW_RESET);
      frame_done   <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    div_d   = div;
    half_d  = half;
    idx_d   = idx;
    shreg_d = shreg;
    dc_d    = dc;
    bc_d    = byte_counter;
    done_d  = 1'b0;
    case (state)
      HW_RESET: begin
        if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = POWER_WAIT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      POWER_WAIT: begin
        if (cnt == CNT_W'(PW_LAST)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = INIT_LOAD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      INIT_LOAD: begin
        shreg_d = init_rom(idx);
        dc_d    = 1'b0;
        div_d   = '0;
        half_d  = '0;
        state_d = SHIFT;
      end
      DATA_ADDR: begin
        // Second cycle: the image controller has registered the new address.
        if (cnt == CNT_W'(1)) begin
          cnt_d   = '0;
          shreg_d = data_to_send;
          dc_d    = 1'b1;
          div_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        // Half 0: CS setup; halves 1..16: bit clocking; half 17: CS high.
        if (div == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (half == 5'd17) begin
            half_d  = '0;
            state_d = NEXT;
          end else begin
            half_d = half + 5'd1;
            if (half[0]) shreg_d = {shreg[6:0], 1'b0};
          end
        end else begin
          div_d = div + 1'b1;
        end
      end
      NEXT: begin
        if (!dc) begin
          if (idx == 5'd30) begin
            bc_d    = '0;
            state_d = DATA_ADDR;
          end else begin
            idx_d   = idx + 5'd1;
            state_d = INIT_LOAD;
          end
        end else if (byte_counter == 10'd1023) begin
          done_d  = 1'b1;
          bc_d    = '0;
          state_d = GAP;
        end else begin
          bc_d    = byte_counter + 10'd1;
          state_d = DATA_ADDR;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(FRAME_GAP - 1)) begin
          cnt_d   = '0;
          state_d = DATA_ADDR;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = HW_RESET;
    endcase
  end

  // Pin values decoded from the current state, then registered so the pins never glitch.
  always_comb begin
    in_shift = (state == SHIFT);
    cs_c     = !(in_shift && (half != 5'd17));
    sclk_c   = in_shift && half[0] && (half < 5'd16);
    sdin_c   = in_shift && (half < 5'd16) && shreg[7];
  end

endmodule

// File: tb/tb_oled_spi_driver.sv
// Bench for oled_spi_driver: main instance (CLK_DIV=2) checked by an SPI decoder against a
// queue of expected bytes, plus a CLK_DIV=1 instance checked against a running address model.
module tb_oled_spi_driver;
  localparam int CD  = 2;
  localparam int RC  = 10;
  localparam int SC  = 5;
  localparam int FG  = 16;
  localparam int CD2 = 1;
  localparam int FG2 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [7:0] init_tab [0:30] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20,
    8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40,
    8'hA4, 8'hA6, 8'hAF, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  logic [7:0] data1, data2;
  logic [9:0] bc1, bc2;
  logic sclk1, sdin1, cs1, dc1, res1, fd1;
  logic sclk2, sdin2, cs2, dc2, res2, fd2;

  oled_spi_driver #(.CLK_DIV(CD), .RESET_CYCLES(RC), .STARTUP_CYCLES(SC), .FRAME_GAP(FG)) dut (
    .clk(clk), .rst_n(rst_n), .data_to_send(data1), .byte_counter(bc1),
    .oled_sclk(sclk1), .oled_sdin(sdin1), .oled_cs(cs1), .oled_dc(dc1),
    .oled_res(res1), .frame_done(fd1));

  oled_spi_driver #(.CLK_DIV(CD2), .RESET_CYCLES(RC), .STARTUP_CYCLES(SC), .FRAME_GAP(FG2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_to_send(data2), .byte_counter(bc2),
    .oled_sclk(sclk2), .oled_sdin(sdin2), .oled_cs(cs2), .oled_dc(dc2),
    .oled_res(res2), .frame_done(fd2));

  // Image controller stubs: registered data one clk after the address.
  always @(posedge clk) begin
    data1 <= bc1[7:0] ^ 8'h5A;
    data2 <= bc2[7:0] ^ 8'h5A;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected entries: {addr[9:0], dc, byte[7:0]}
  logic [18:0] q[$];
  int bits1 = 0;
  int idle_err = 0, spacing_err = 0, dc_err = 0, period_err = 0;
  int frames2_tot = 0;

  task automatic push_init();
    for (int i = 0; i < 31; i++) q.push_back({10'd0, 1'b0, init_tab[i]});
  endtask

  task automatic push_frame();
    for (int a = 0; a < 1024; a++) q.push_back({10'(a), 1'b1, 8'(a) ^ 8'h5A});
  endtask

  // SPI decoder for the main instance
  initial begin
    int t_fall, t_rise;
    logic prev_cs, prev_sclk, dcf, last_dc;
    logic [9:0] bcf;
    logic [7:0] sh;
    logic [18:0] e;
    t_fall = 0; t_rise = 0; prev_cs = 1'b1; prev_sclk = 1'b0; last_dc = 1'b0;
    dcf = 1'b0; bcf = '0; sh = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bits1 = 0; prev_cs = 1'b1; prev_sclk = 1'b0; last_dc = 1'b0;
      end else begin
        if (cs1 && sclk1) idle_err++;
        if (prev_cs && !cs1) begin
          if (dc1 && last_dc && bc1 != 10'd0 && (cyc - t_fall) != 3 + 18 * CD) period_err++;
          t_fall = cyc; bits1 = 0; dcf = dc1; bcf = bc1; last_dc = dc1;
        end
        if (!cs1 && dc1 !== dcf) dc_err++;
        if (!cs1 && sclk1 && !prev_sclk) begin
          if (bits1 == 0) check("first_rise", cyc - t_fall, CD);
          else if ((cyc - t_rise) != 2 * CD) spacing_err++;
          t_rise = cyc;
          sh = {sh[6:0], sdin1};
          bits1++;
          if (bits1 == 8) begin
            if (q.size() == 0) check("spi_unexpected_byte", {dcf, sh}, 32'h1FF);
            else begin
              e = q.pop_front();
              check("spi_byte", {dcf, sh}, e[8:0]);
              if (dcf) check("spi_addr", bcf, e[18:9]);
            end
          end
        end
        prev_cs = cs1; prev_sclk = sclk1;
      end
    end
  end

  // Decoder and address model for the CLK_DIV=1 instance
  initial begin
    int bits2, t_rise2, addr2, init2, frames2;
    logic prev_cs, prev_sclk, dcf;
    logic [9:0] bcf;
    logic [7:0] sh;
    bits2 = 0; t_rise2 = 0; addr2 = 0; init2 = 0; frames2 = 0;
    prev_cs = 1'b1; prev_sclk = 1'b0; dcf = 1'b0; bcf = '0; sh = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bits2 = 0; addr2 = 0; init2 = 0; frames2 = 0; prev_cs = 1'b1; prev_sclk = 1'b0;
      end else begin
        if (cs2 && sclk2) idle_err++;
        if (prev_cs && !cs2) begin bits2 = 0; dcf = dc2; bcf = bc2; end
        if (!cs2 && sclk2 && !prev_sclk) begin
          if (bits2 != 0 && (cyc - t_rise2) != 2 * CD2) spacing_err++;
          t_rise2 = cyc;
          sh = {sh[6:0], sdin2};
          bits2++;
          if (bits2 == 8) begin
            if (!dcf) begin
              check("c1_init_byte", {(frames2 == 0 && init2 < 31), sh},
                    {1'b1, init_tab[(init2 < 31) ? init2 : 0]});
              init2++;
            end else begin
              if (addr2 == 0 && frames2 == 0) check("c1_init_count", init2, 31);
              check("c1_data", {bcf, sh}, {10'(addr2), 8'(addr2) ^ 8'h5A});
              addr2++;
            end
          end
        end
        if (fd2) begin
          check("c1_frame_len", addr2, 1024);
          addr2 = 0; frames2++; frames2_tot++;
        end
        prev_cs = cs2; prev_sclk = sclk2;
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_bc", bc1, 0);
    check("rst_sclk", sclk1, 0);
    check("rst_sdin", sdin1, 0);
    check("rst_cs", cs1, 1);
    check("rst_dc", dc1, 0);
    check("rst_res", res1, 0);
    check("rst_frame_done", fd1, 0);
    check("rst_c1_cs", cs2, 1);
    push_init();
    push_frame();
    rst_n = 1'b1;

    n = 0;
    do begin @(negedge clk); if (!res1) n++; end while (!res1 && n < 200);
    check("res_low_clks", n, RC);
    n = 0;
    do begin @(negedge clk); n++; end while (cs1 && n < 200);
    check("res_to_first_cs", n, SC);

    n = 0;
    while (!fd1 && n < 45000) begin @(negedge clk); n++; end
    check("frame1_done_seen", fd1, 1);
    check("frame_end_bc", bc1, 0);
    check("frame_all_bytes_sent", q.size(), 0);
    push_frame();
    @(negedge clk);
    check("frame_done_width", fd1, 0);
    n = cs1 ? 1 : 0;
    while (cs1 && n < 200) begin @(negedge clk); if (cs1) n++; end
    check("frame_gap_clks", n, FG + 2);

    n = 0;
    while (!(bc1 == 10'd500 && !cs1 && bits1 == 3) && n < 30000) begin @(negedge clk); n++; end
    check("reach_byte500_bit3", {bc1, 8'(bits1)}, {10'd500, 8'd3});
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cs", cs1, 1);
    check("abort_sclk", sclk1, 0);
    check("abort_res", res1, 0);
    check("abort_bc", bc1, 0);
    check("abort_frame_done", fd1, 0);
    q.delete();
    push_init();
    push_frame();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (q.size() > 1016 && n < 5000) begin @(negedge clk); n++; end
    check("reinit_bytes_consumed", q.size(), 1016);

    check("sclk_idle_when_cs_high", idle_err, 0);
    check("sclk_period", spacing_err, 0);
    check("dc_stable", dc_err, 0);
    check("data_byte_period", period_err, 0);
    check("c1_frames_completed", frames2_tot >= 2, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
